ro_bank_seq: RTL and testbench

- Measurement sequencer for the ring-oscillator bank.
- Each measurement clears the RO counters, enables the oscillators for a programmed window, waits for counter synchronisers to settle, snapshots all counts, then streams them out one per handshake.
- Sits between the AXI4-Lite register slave (which supplies start/stop/config) and the RO bank counters.
- The output stream feeds the capture FIFO read by software.

---
 rtl/ro_bank_seq.sv | 163 ++++++++++++++++
 tb/tb_ro_bank_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_bank_seq.sv
// Ring-oscillator bank measurement sequencer.
// Clears the RO counters, enables the oscillators for a programmed window,
// lets the counter synchronisers settle, snapshots every count and then
// streams the counts out one per valid/ready handshake.
module ro_bank_seq #(
    parameter int N_RO   = 8,
    parameter int CNT_W  = 32,
    parameter int WIN_W  = 16,
    parameter int SETTLE = 4,
    parameter int MEAS_W = 16,
    localparam int IDX_W = $clog2(N_RO)
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    continuous,
    input  logic [WIN_W-1:0]        win_len,
    output logic                    ro_clr,
    output logic                    ro_en,
    input  logic [N_RO*CNT_W-1:0]   ro_cnt,
    output logic [CNT_W-1:0]        m_data,
    output logic [IDX_W-1:0]        m_idx,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic                    busy,
    output logic                    done,
    output logic                    abort,
    output logic                    cfg_err,
    output logic [MEAS_W-1:0]       meas_cnt
);

    localparam int SET_W = $clog2(SETTLE + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_RO - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SETTLE_ST,
        DRAIN
    } state_t;

    state_t             state;
    logic [WIN_W-1:0]   win_cnt;
    logic [SET_W-1:0]   settle_cnt;
    logic [IDX_W-1:0]   idx;
    logic               stop_pending;
    logic [CNT_W-1:0]   snap [N_RO];

    // Stream presentation is a pure selection of registered state.
    assign m_idx  = idx;
    assign m_data = snap[idx];
    assign m_last = m_valid && (idx == LAST_IDX);

    // Sequencer: state, counters, snapshot and all registered outputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state        <= IDLE;
            win_cnt      <= '0;
            settle_cnt   <= '0;
            idx          <= '0;
            stop_pending <= 1'b0;
            for (int unsigned k = 0; k < N_RO; k++) begin
                snap[k] <= '0;
            end
            ro_clr   <= 1'b0;
            ro_en    <= 1'b0;
            m_valid  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            abort    <= 1'b0;
            cfg_err  <= 1'b0;
            meas_cnt <= '0;
        end else begin
            ro_clr  <= 1'b0;
            done    <= 1'b0;
            abort   <= 1'b0;
            cfg_err <= 1'b0;

            if (stop && (state == CLEAR || state == RUN || state == SETTLE_ST)) begin
                state <= IDLE;
                ro_en <= 1'b0;
                busy  <= 1'b0;
                abort <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        stop_pending <= 1'b0;
                        if (start && !stop) begin
                            if (win_len == '0) begin
                                cfg_err <= 1'b1;
                            end else begin
                                state  <= CLEAR;
                                ro_clr <= 1'b1;
                                busy   <= 1'b1;
                            end
                        end
                    end
                    CLEAR: begin
                        win_cnt <= win_len;
                        ro_en   <= 1'b1;
                        state   <= RUN;
                    end
                    RUN: begin
                        // A zero window latched on a re-arm ends after one cycle
                        // instead of wrapping the down-counter.
                        if (win_cnt == WIN_W'(1) || win_cnt == '0) begin
                            ro_en      <= 1'b0;
                            settle_cnt <= SET_W'(SETTLE - 1);
                            state      <= SETTLE_ST;
                        end else begin
                            win_cnt <= win_cnt - 1'b1;
                        end
                    end
                    SETTLE_ST: begin
                        if (settle_cnt == '0) begin
                            for (int unsigned k = 0; k < N_RO; k++) begin
                                snap[k] <= ro_cnt[k*CNT_W +: CNT_W];
                            end
                            idx     <= '0;
                            m_valid <= 1'b1;
                            state   <= DRAIN;
                        end else begin
                            settle_cnt <= settle_cnt - 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (stop) begin
                            stop_pending <= 1'b1;
                        end
                        if (m_ready) begin
                            if (idx == LAST_IDX) begin
                                idx      <= '0;
                                meas_cnt <= meas_cnt + 1'b1;
                                m_valid  <= 1'b0;
                                if (continuous && !stop_pending && !stop) begin
                                    state  <= CLEAR;
                                    ro_clr <= 1'b1;
                                end else begin
                                    state        <= IDLE;
                                    busy         <= 1'b0;
                                    done         <= 1'b1;
                                    stop_pending <= 1'b0;
                                end
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        ro_en   <= 1'b0;
                        m_valid <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ro_bank_seq.sv
// Scoreboard bench for ro_bank_seq: expected beats are queued at start,
// a negedge monitor pops and compares on every handshake.
module tb_ro_bank_seq;

    localparam int N  = 8;
    localparam int CW = 32;
    localparam int WW = 16;
    localparam int ST = 4;
    localparam int MW = 16;

    logic              ACLK = 1'b0;
    logic              ARESETN = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              continuous = 1'b0;
    logic [WW-1:0]     win_len = '0;
    logic              ro_clr;
    logic              ro_en;
    logic [N*CW-1:0]   ro_cnt = '0;
    logic [CW-1:0]     m_data;
    logic [2:0]        m_idx;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              m_last;
    logic              busy;
    logic              done;
    logic              abort;
    logic              cfg_err;
    logic [MW-1:0]     meas_cnt;

    ro_bank_seq #(.N_RO(N), .CNT_W(CW), .WIN_W(WW), .SETTLE(ST), .MEAS_W(MW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .stop(stop),
        .continuous(continuous), .win_len(win_len), .ro_clr(ro_clr), .ro_en(ro_en),
        .ro_cnt(ro_cnt), .m_data(m_data), .m_idx(m_idx), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done),
        .abort(abort), .cfg_err(cfg_err), .meas_cnt(meas_cnt)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [CW-1:0] data;
        logic [2:0]    idx;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [CW-1:0] cnt_arr [N];
    logic [MW-1:0] exp_meas = '0;
    int            errors = 0;
    int            checks = 0;
    int            rmode = 0;

    int unsigned n_en = 0, n_clr = 0, n_beat = 0, n_done = 0, n_busy = 0;
    int unsigned n_gap = 0, n_abort = 0, n_cfg = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // m_ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random
    logic [3:0] pat = 4'b1001;
    int         ph = 0;
    always @(posedge ACLK) begin
        #1;
        case (rmode)
            1: begin m_ready = pat[ph]; ph = (ph + 1) % 4; end
            2: m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b1;
        endcase
    end

    // Monitor: event counters, stall stability and scoreboard pops
    logic          prev_valid = 1'b0, prev_ready = 1'b0;
    logic [CW-1:0] prev_data = '0;
    logic [2:0]    prev_idx = '0;
    always @(negedge ACLK) begin
        beat_t b;
        if (ro_en) n_en++;
        if (ro_clr) n_clr++;
        if (done) n_done++;
        if (busy) n_busy++;
        if (abort) n_abort++;
        if (cfg_err) n_cfg++;
        if (busy && !ro_en && !ro_clr && !m_valid) n_gap++;
        if (ARESETN && prev_valid && !prev_ready) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, prev_data);
            check("stall_idx", m_idx, prev_idx);
        end
        if (m_valid && m_ready) begin
            n_beat++;
            if (exp_q.size() == 0) begin
                check("beat_unexpected", 1, 0);
            end else begin
                b = exp_q.pop_front();
                check("beat_data", m_data, b.data);
                check("beat_idx", m_idx, b.idx);
                check("beat_last", m_last, b.last);
            end
        end
        prev_valid = m_valid && ARESETN;
        prev_ready = m_ready;
        prev_data  = m_data;
        prev_idx   = m_idx;
    end

    task automatic tick();
        @(negedge ACLK);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge ACLK); #1 start = 1'b1;
        @(posedge ACLK); #1 start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge ACLK); #1 stop = 1'b1;
        @(posedge ACLK); #1 stop = 1'b0;
    endtask

    task automatic load_cnts(input bit seq);
        for (int k = 0; k < N; k++) begin
            cnt_arr[k] = seq ? CW'(k + 10) : $urandom;
            ro_cnt[k*CW +: CW] = cnt_arr[k];
        end
    endtask

    task automatic push_expected();
        beat_t b;
        for (int k = 0; k < N; k++) begin
            b.data = cnt_arr[k];
            b.idx  = 3'(k);
            b.last = (k == N - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_done(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic run_meas(input int win, input int mode, input bit seq);
        int unsigned en0 = n_en, clr0 = n_clr, beat0 = n_beat, done0 = n_done;
        int unsigned busy0 = n_busy, gap0 = n_gap;
        logic ok;
        load_cnts(seq);
        win_len = WW'(win);
        rmode = mode;
        push_expected();
        exp_meas = exp_meas + 1'b1;
        pulse_start();
        wait_done(4000, ok);
        check("done_seen", ok, 1);
        check("meas_cnt", meas_cnt, exp_meas);
        check("busy_after", busy, 0);
        check("queue_drained", exp_q.size(), 0);
        check("ro_en_cycles", n_en - en0, win);
        check("ro_clr_cycles", n_clr - clr0, 1);
        check("settle_gap", n_gap - gap0, ST);
        check("beats", n_beat - beat0, N);
        check("done_pulses", n_done - done0, 1);
        if (mode == 0) check("busy_cycles", n_busy - busy0, 1 + win + ST + N);
    endtask

    initial begin
        int unsigned c0, c1, c2;
        logic ok;

        // reset state
        repeat (3) tick();
        check("rst_ro_clr", ro_clr, 0);
        check("rst_ro_en", ro_en, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {done, abort, cfg_err, m_last}, 0);
        check("rst_meas_cnt", meas_cnt, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_idx", m_idx, 0);
        @(posedge ACLK); #1 ARESETN = 1'b1;
        repeat (2) tick();

        // basic measurement, then backpressure pattern
        run_meas(100, 0, 1'b1);
        run_meas(7, 1, 1'b0);

        // zero window
        c0 = n_clr; c1 = n_en; c2 = n_cfg;
        win_len = '0;
        pulse_start();
        tick();
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_busy", busy, 0);
        repeat (5) tick();
        check("cfg_err_count", n_cfg - c2, 1);
        check("cfg_no_clr", n_clr - c0, 0);
        check("cfg_no_en", n_en - c1, 0);

        // start and stop together
        c0 = n_clr; c1 = n_abort; c2 = n_cfg;
        win_len = 16'd5;
        @(posedge ACLK); #1 start = 1'b1; stop = 1'b1;
        @(posedge ACLK); #1 start = 1'b0; stop = 1'b0;
        repeat (3) tick();
        check("startstop_busy", busy, 0);
        check("startstop_clr", n_clr - c0, 0);
        check("startstop_pulses", (n_abort - c1) + (n_cfg - c2), 0);

        // continuous mode, stop during the third drain
        c0 = n_done; c1 = n_beat; c2 = n_busy;
        continuous = 1'b1;
        rmode = 0;
        win_len = 16'd10;
        load_cnts(1'b0);
        repeat (3) push_expected();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (meas_cnt == exp_meas + 2 && m_valid) begin ok = 1'b1; break; end
        end
        check("cont_third_drain", ok, 1);
        check("cont_no_early_done", n_done - c0, 0);
        pulse_stop();
        wait_done(200, ok);
        check("cont_done_seen", ok, 1);
        exp_meas = exp_meas + 3;
        continuous = 1'b0;
        check("cont_meas_cnt", meas_cnt, exp_meas);
        check("cont_done_pulses", n_done - c0, 1);
        check("cont_beats", n_beat - c1, 3 * N);
        check("cont_busy_cycles", n_busy - c2, 3 * (1 + 10 + ST + N));
        check("cont_queue", exp_q.size(), 0);

        // abort mid-window
        c0 = n_en; c1 = n_beat; c2 = n_abort;
        win_len = 16'd100;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (n_en - c0 >= 50) begin ok = 1'b1; break; end
        end
        check("abort_reach50", ok, 1);
        pulse_stop();
        tick();
        check("abort_ro_en", ro_en, 0);
        check("abort_pulse", abort, 1);
        check("abort_busy", busy, 0);
        repeat (10) tick();
        check("abort_en_cycles", n_en - c0, 51);
        check("abort_no_beats", n_beat - c1, 0);
        check("abort_count", n_abort - c2, 1);
        check("abort_meas_cnt", meas_cnt, exp_meas);

        // randomized measurements
        for (int r = 0; r < 4; r++) begin
            run_meas($urandom_range(1, 20), $urandom_range(0, 2), 1'b0);
        end

        // reset mid-window
        c0 = n_en;
        win_len = 16'd100;
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            tick();
            if (n_en - c0 >= 20) break;
        end
        #1 ARESETN = 1'b0;
        #1;
        check("arst_ro_en", ro_en, 0);
        check("arst_m_valid", m_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_meas_cnt", meas_cnt, 0);
        check("arst_m_data", m_data, 0);
        exp_meas = '0;
        @(posedge ACLK); #1 ARESETN = 1'b1;
        repeat (2) tick();
        check("arst_queue", exp_q.size(), 0);
        run_meas(12, 0, 1'b0);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
